// File: rtl/tlb_cmd_ctrl_if.sv
// Command/response port between the writeback stage and the TLB command sequencer.
// The writeback stage is the master; the sequencer is the slave.
interface tlb_cmd_ctrl_if #(
    parameter int unsigned IDXW = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [36:0]       cmd_bus;
    logic [143:0]      csr_bus;
    logic              rsp_valid;
    logic [4+IDXW:0]   rsp_bus;

    modport master (
        output cmd_valid, cmd_bus, csr_bus,
        input  cmd_ready, rsp_valid, rsp_bus
    );

    modport slave (
        input  cmd_valid, cmd_bus, csr_bus,
        output cmd_ready, rsp_valid, rsp_bus
    );
endinterface

// File: rtl/tlb_cmd_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: one EXEC cycle driving the TLB ports,
// then a one-cycle response carrying the results the CSR file needs.
module tlb_cmd_ctrl #(
    parameter int unsigned TLBNUM = 16,
    localparam int unsigned IDXW = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              resetn,
    tlb_cmd_ctrl_if.slave     cmd_if,
    input  logic [29:0]       mem_s1_in,
    output logic              mem_stall,
    output logic [29:0]       tlb_s1_out,
    input  logic              tlb_s1_found,
    input  logic [IDXW-1:0]   tlb_s1_index,
    output logic [IDXW-1:0]   tlb_r_index,
    input  logic              tlb_r_e,
    output logic              tlb_inv_valid,
    output logic [4:0]        tlb_inv_op,
    output logic              tlb_we,
    output logic [IDXW-1:0]   tlb_w_index,
    output logic [88:0]       tlb_w_bus
);

    localparam logic [2:0] OpSrch = 3'd0;
    localparam logic [2:0] OpRd   = 3'd1;
    localparam logic [2:0] OpWr   = 3'd2;
    localparam logic [2:0] OpFill = 3'd3;
    localparam logic [2:0] OpInv  = 3'd4;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q;
    logic [36:0]       cmd_q;
    logic [143:0]      csr_q;
    logic [IDXW-1:0]   fill_cnt_q;
    logic [IDXW-1:0]   fill_idx_q;
    logic              rsp_valid_q;
    logic [4+IDXW:0]   rsp_q;
    logic [4+IDXW:0]   rsp_d;

    logic [2:0]  op;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [5:0]  ecode;
    logic [9:0]  asid;
    logic [31:0] ehi, idx, elo1, elo0;
    logic        exec, is_srch, is_inv, inv_ok;
    logic        rsp_err, rsp_ne;
    logic [IDXW-1:0] rsp_idx;
    logic        unused_csr;

    assign op       = cmd_q[36:34];
    assign inv_op   = cmd_q[33:29];
    assign inv_asid = cmd_q[28:19];
    assign inv_vppn = cmd_q[18:0];
    assign ecode    = csr_q[143:138];
    assign asid     = csr_q[137:128];
    assign ehi      = csr_q[127:96];
    assign idx      = csr_q[95:64];
    assign elo1     = csr_q[63:32];
    assign elo0     = csr_q[31:0];

    assign unused_csr = ^{idx[30], idx[23:IDXW], elo1[31:28], elo1[7], elo0[31:28], elo0[7]};

    assign exec    = (state_q == StExec);
    assign is_srch = (op == OpSrch);
    assign is_inv  = (op == OpInv);
    assign inv_ok  = (inv_op <= 5'd6);

    assign cmd_if.cmd_ready = (state_q == StIdle);
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_bus   = rsp_q;

    // Strobes are gated by resetn so a reset landing in EXEC never reaches the TLB.
    assign tlb_we        = exec && (op == OpWr || op == OpFill) && resetn;
    assign tlb_inv_valid = exec && is_inv && inv_ok && resetn;
    assign tlb_inv_op    = inv_op;
    assign mem_stall     = exec && (is_srch || is_inv);
    assign tlb_r_index   = idx[IDXW-1:0];
    assign tlb_w_index   = (op == OpFill) ? fill_idx_q : idx[IDXW-1:0];

    assign tlb_w_bus = {
        (ecode == 6'h3F) ? 1'b1 : ~idx[31],
        idx[29:24],
        ehi[31:13],
        asid,
        elo0[6] & elo1[6],
        elo1[27:8], elo1[3:2], elo1[5:4], elo1[1], elo1[0],
        elo0[27:8], elo0[3:2], elo0[5:4], elo0[1], elo0[0]
    };

    always_comb begin
        tlb_s1_out = mem_s1_in;
        if (exec && is_srch) begin
            tlb_s1_out = {ehi[31:13], 1'b0, asid};
        end else if (exec && is_inv) begin
            tlb_s1_out = {inv_vppn, 1'b0, inv_asid};
        end
    end

    always_comb begin
        rsp_err = 1'b0;
        rsp_ne  = 1'b0;
        rsp_idx = '0;
        unique case (op)
            OpSrch: begin
                rsp_ne  = ~tlb_s1_found;
                rsp_idx = tlb_s1_found ? tlb_s1_index : '0;
            end
            OpRd: begin
                rsp_ne  = ~tlb_r_e;
                rsp_idx = tlb_r_index;
            end
            OpWr, OpFill: rsp_idx = tlb_w_index;
            OpInv:        rsp_err = ~inv_ok;
            default:      rsp_err = 1'b1;
        endcase
        rsp_d = {rsp_err, rsp_ne, op, rsp_idx};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            csr_q       <= '0;
            fill_cnt_q  <= '0;
            fill_idx_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            fill_cnt_q  <= (fill_cnt_q == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_if.cmd_valid) begin
                        cmd_q      <= cmd_if.cmd_bus;
                        csr_q      <= cmd_if.csr_bus;
                        fill_idx_q <= fill_cnt_q;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid_q <= 1'b1;
                    rsp_q       <= rsp_d;
                    state_q     <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_cmd_ctrl.sv
// Randomized self-checking bench for tlb_cmd_ctrl against a transaction-level reference model.
module tb_tlb_cmd_ctrl;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IDXW   = $clog2(TLBNUM);

    logic            clk = 1'b0;
    logic            resetn;
    logic [29:0]     mem_s1_in;
    logic            mem_stall;
    logic [29:0]     tlb_s1_out;
    logic            tlb_s1_found;
    logic [IDXW-1:0] tlb_s1_index;
    logic [IDXW-1:0] tlb_r_index;
    logic            tlb_r_e;
    logic            tlb_inv_valid;
    logic [4:0]      tlb_inv_op;
    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_index;
    logic [88:0]     tlb_w_bus;

    int n_vec = 0;
    int n_err = 0;
    int fill_m = 0;

    tlb_cmd_ctrl_if #(.IDXW(IDXW)) cif ();

    tlb_cmd_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_if        (cif.slave),
        .mem_s1_in     (mem_s1_in),
        .mem_stall     (mem_stall),
        .tlb_s1_out    (tlb_s1_out),
        .tlb_s1_found  (tlb_s1_found),
        .tlb_s1_index  (tlb_s1_index),
        .tlb_r_index   (tlb_r_index),
        .tlb_r_e       (tlb_r_e),
        .tlb_inv_valid (tlb_inv_valid),
        .tlb_inv_op    (tlb_inv_op),
        .tlb_we        (tlb_we),
        .tlb_w_index   (tlb_w_index),
        .tlb_w_bus     (tlb_w_bus)
    );

    always #5 clk = ~clk;

    // Fill counter model: cycles since reset release, modulo the entry count.
    always @(posedge clk) fill_m <= !resetn ? 0 : (fill_m + 1) % TLBNUM;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] lo_of(input logic [31:0] elo);
        logic [19:0] ppn;
        logic [1:0]  plv, mat;
        ppn = elo[27:8];
        plv = elo[3:2];
        mat = elo[5:4];
        return {ppn, plv, mat, elo[1], elo[0]};
    endfunction

    function automatic logic [88:0] exp_wbus(input logic [5:0] ecode, input logic [9:0] asid,
                                             input logic [31:0] ehi, input logic [31:0] idx,
                                             input logic [31:0] elo1, input logic [31:0] elo0);
        logic e;
        e = (ecode == 6'h3F) ? 1'b1 : !idx[31];
        return {e, idx[29:24], ehi[31:13], asid, elo0[6] && elo1[6], lo_of(elo1), lo_of(elo0)};
    endfunction

    task automatic idle_checks();
        check_eq("idle_ready", cif.cmd_ready, 1);
        check_eq("idle_rsp_valid", cif.rsp_valid, 0);
        check_eq("idle_we", tlb_we, 0);
        check_eq("idle_inv", tlb_inv_valid, 0);
        check_eq("idle_stall", mem_stall, 0);
        check_eq("idle_s1_pass", tlb_s1_out, mem_s1_in);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        mem_s1_in = 30'($urandom);
        #1;
        idle_checks();
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] iasid,
                           input logic [18:0] ivppn, input logic [5:0] ecode,
                           input logic [9:0] asid, input logic [31:0] ehi,
                           input logic [31:0] idx, input logic [31:0] elo1,
                           input logic [31:0] elo0, input logic found,
                           input logic [IDXW-1:0] sidx, input logic re, input bit rst_exec);
        int fill_at;
        logic exp_we, exp_inv, exp_err, exp_ne;
        logic [IDXW-1:0] exp_widx, exp_ridx;
        logic [29:0] exp_s1;
        logic [4+IDXW:0] exp_rsp;
        logic [IDXW-1:0] exp_idx;

        @(negedge clk);
        mem_s1_in = 30'($urandom);
        cif.cmd_valid = 1'b1;
        cif.cmd_bus = {op, iop, iasid, ivppn};
        cif.csr_bus = {ecode, asid, ehi, idx, elo1, elo0};
        fill_at = fill_m;
        #1;
        idle_checks();

        exp_ridx = idx[IDXW-1:0];
        exp_we   = (op == 3'd2) || (op == 3'd3);
        exp_inv  = (op == 3'd4) && (iop <= 5'd6);
        exp_widx = (op == 3'd3) ? IDXW'(fill_at) : exp_ridx;
        exp_s1   = 30'(0);
        exp_err  = (op > 3'd4) || ((op == 3'd4) && (iop > 5'd6));
        exp_ne   = 1'b0;
        exp_idx  = '0;
        case (op)
            3'd0: begin exp_ne = !found; exp_idx = found ? sidx : '0; end
            3'd1: begin exp_ne = !re; exp_idx = exp_ridx; end
            3'd2, 3'd3: exp_idx = exp_widx;
            default: ;
        endcase
        exp_rsp = {exp_err, exp_ne, op, exp_idx};

        // EXEC cycle; cmd_valid must be ignored here.
        @(negedge clk);
        cif.cmd_valid = 1'($urandom);
        cif.cmd_bus = 37'($urandom);
        mem_s1_in = 30'($urandom);
        tlb_s1_found = found;
        tlb_s1_index = sidx;
        tlb_r_e = re;
        if (rst_exec) resetn = 1'b0;
        if (op == 3'd0) exp_s1 = {ehi[31:13], 1'b0, asid};
        else if (op == 3'd4) exp_s1 = {ivppn, 1'b0, iasid};
        else exp_s1 = mem_s1_in;
        #1;
        check_eq("exec_ready", cif.cmd_ready, 0);
        check_eq("exec_rsp_valid", cif.rsp_valid, 0);
        check_eq("exec_we", tlb_we, rst_exec ? 1'b0 : exp_we);
        check_eq("exec_inv", tlb_inv_valid, rst_exec ? 1'b0 : exp_inv);
        check_eq("exec_stall", mem_stall, (op == 3'd0) || (op == 3'd4));
        check_eq("exec_s1_out", tlb_s1_out, exp_s1);
        if (exp_we) begin
            check_eq("exec_w_index", tlb_w_index, exp_widx);
            check_eq("exec_w_bus", tlb_w_bus, exp_wbus(ecode, asid, ehi, idx, elo1, elo0));
        end
        if (op == 3'd1) check_eq("exec_r_index", tlb_r_index, exp_ridx);
        if (exp_inv) check_eq("exec_inv_op", tlb_inv_op, iop);

        if (rst_exec) begin
            @(negedge clk);
            resetn = 1'b1;
            cif.cmd_valid = 1'b0;
            mem_s1_in = 30'($urandom);
            #1;
            idle_checks();
        end else begin
            @(negedge clk);
            cif.cmd_valid = 1'($urandom);
            mem_s1_in = 30'($urandom);
            #1;
            check_eq("resp_ready", cif.cmd_ready, 0);
            check_eq("resp_valid", cif.rsp_valid, 1);
            check_eq("resp_bus", cif.rsp_bus, exp_rsp);
            check_eq("resp_we", tlb_we, 0);
            check_eq("resp_inv", tlb_inv_valid, 0);
            check_eq("resp_stall", mem_stall, 0);
            check_eq("resp_s1_pass", tlb_s1_out, mem_s1_in);
        end
    endtask

    task automatic wait_fill(input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * TLBNUM && !hit; i++) begin
            if (fill_m == (v + TLBNUM - 1) % TLBNUM) hit = 1'b1;
            else idle_cycle();
        end
        check_eq("fill_wait", hit, 1);
    endtask

    logic [31:0] wr_idx;

    initial begin
        resetn = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_bus = '0;
        cif.csr_bus = '0;
        mem_s1_in = '0;
        tlb_s1_found = 1'b0;
        tlb_s1_index = '0;
        tlb_r_e = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_rsp_bus", cif.rsp_bus, 0);
        check_eq("rst_rsp_valid", cif.rsp_valid, 0);
        resetn = 1'b1;
        idle_cycle();
        check_eq("rst_rsp_bus_after", cif.rsp_bus, 0);

        wr_idx = {1'b1, 1'b0, 6'd12, 20'd0, 4'd3};
        run_txn(3'd2, 5'd0, 10'd0, 19'd0, 6'd0, 10'h155, $urandom, wr_idx,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);

        wait_fill(5);
        run_txn(3'd3, 5'd0, 10'd0, 19'd0, 6'h3F, 10'h0AA, $urandom, 32'h8000_0000 | $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);
        run_txn(3'd3, 5'd0, 10'd0, 19'd0, 6'h3F, 10'h0AA, $urandom, 32'h8000_0000 | $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);

        run_txn(3'd0, 5'd0, 10'd0, 19'd0, 6'd0, 10'h02A, {19'h12345, 13'($urandom)}, $urandom,
                $urandom, $urandom, 1'b1, 4'd9, 1'b0, 1'b0);
        run_txn(3'd0, 5'd0, 10'd0, 19'd0, 6'd0, 10'h02A, {19'h12345, 13'($urandom)}, $urandom,
                $urandom, $urandom, 1'b0, 4'd9, 1'b0, 1'b0);

        run_txn(3'd4, 5'd5, 10'h003, 19'h01000, 6'd0, $urandom, $urandom, $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);
        run_txn(3'd4, 5'd7, 10'h003, 19'h01000, 6'd0, $urandom, $urandom, $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);

        run_txn(3'd1, 5'd0, 10'd0, 19'd0, 6'd0, $urandom, $urandom, 32'd4,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);
        run_txn(3'd6, 5'd0, 10'd0, 19'd0, 6'd0, $urandom, $urandom, $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b0);

        run_txn(3'd2, 5'd0, 10'd0, 19'd0, 6'd0, $urandom, $urandom, $urandom,
                $urandom, $urandom, 1'b0, '0, 1'b0, 1'b1);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] ec;
            ec = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
            run_txn(3'($urandom), ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 6))
                                                            : 5'($urandom),
                    10'($urandom), 19'($urandom), ec, 10'($urandom), $urandom, $urandom,
                    $urandom, $urandom, 1'($urandom), IDXW'($urandom), 1'($urandom),
                    ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
